// File: rtl/qdec_lb_pkg.sv
// Shared definitions for the CABAC syntax line-buffer write side: record size,
// address width, packer states and the byte map used by producers and consumers.
package qdec_lb_pkg;

   localparam int CTU_BYTES = 2192;
   localparam int ADDR_W    = 12;

   // Byte offsets of each syntax region inside one CTU record.
   localparam int LB_OFS_SAO = 0;
   localparam int LB_OFS_TOP = 13;
   localparam int LB_OFS_CQT = 16;
   localparam int LB_OFS_CU  = 24;

   typedef enum logic [2:0] {
      LB_IDLE,
      LB_CLEAR,
      LB_ACTIVE,
      LB_FLUSH,
      LB_SWITCH
   } lb_pk_state_t;

   // Replace the bits [bitofs +: width] of old_byte with the low bits of value.
   // Callers guarantee 1 <= width and bitofs + width <= 8.
   function automatic logic [7:0] lb_merge_byte(
      input logic [7:0] old_byte,
      input logic [2:0] bitofs,
      input logic [3:0] width,
      input logic [7:0] value
   );
      logic [15:0] mask;
      logic [15:0] field;
      mask  = ((16'd1 << width) - 16'd1) << bitofs;
      field = {8'd0, value} << bitofs;
      return (old_byte & ~mask[7:0]) | (field[7:0] & mask[7:0]);
   endfunction

endpackage

// File: rtl/qdec_lb_packer.sv
// Packs decoded syntax fields into byte images and writes them into the
// ping-pong line buffer; clears each CTU record first and swaps banks at the end.
module qdec_lb_packer #(
   parameter int CTU_BYTES = qdec_lb_pkg::CTU_BYTES,
   parameter int ADDR_W    = qdec_lb_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ctu_start,
   input  logic              ctu_done,
   input  logic              se_valid,
   output logic              se_ready,
   input  logic [ADDR_W-1:0] se_addr,
   input  logic [2:0]        se_bitofs,
   input  logic [3:0]        se_width,
   input  logic [7:0]        se_value,
   output logic [ADDR_W-1:0] lb_waddr,
   output logic [7:0]        lb_din,
   output logic              lb_we,
   output logic              lb_switch,
   output logic              busy,
   output logic              err
);
   import qdec_lb_pkg::*;

   // One spare count beyond the last address lets CLEAR hold until its final
   // write is on the port, so no field write can overtake the clear.
   localparam int                CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  CTU_END = CNT_W'(CTU_BYTES);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   lb_pk_state_t      state_q, state_d;
   logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [7:0]        pend_byte_q, pend_byte_d;

   logic              we_d, switch_d, err_d;
   logic [ADDR_W-1:0] waddr_d;
   logic [7:0]        din_d;

   logic              accept;
   logic              field_ok;
   logic [4:0]        field_end;

   assign se_ready  = (state_q == LB_ACTIVE);
   assign accept    = se_valid && se_ready;
   assign field_end = {2'b00, se_bitofs} + {1'b0, se_width};
   assign field_ok  = (se_width != 4'd0) && (field_end <= 5'd8) &&
                      ({1'b0, se_addr} < CTU_END);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_byte_d  = pend_byte_q;
      we_d         = 1'b0;
      waddr_d      = lb_waddr;
      din_d        = lb_din;
      switch_d     = 1'b0;
      err_d        = err;

      if (ctu_start && state_q != LB_IDLE) err_d = 1'b1;
      if (ctu_done && state_q != LB_ACTIVE) err_d = 1'b1;

      case (state_q)
         LB_IDLE: begin
            if (ctu_start) begin
               state_d   = LB_CLEAR;
               clr_cnt_d = '0;
            end
         end

         LB_CLEAR: begin
            pend_valid_d = 1'b0;
            if (clr_cnt_q == CTU_END) begin
               state_d = LB_ACTIVE;
            end else begin
               we_d      = 1'b1;
               waddr_d   = clr_cnt_q[ADDR_W-1:0];
               din_d     = 8'h00;
               clr_cnt_d = clr_cnt_q + CNT_ONE;
            end
         end

         LB_ACTIVE: begin
            // A field arriving with ctu_done is merged before the flush.
            if (accept) begin
               if (!field_ok) begin
                  err_d = 1'b1;
               end else if (pend_valid_q && se_addr == pend_addr_q) begin
                  pend_byte_d = lb_merge_byte(pend_byte_q, se_bitofs, se_width, se_value);
               end else begin
                  if (pend_valid_q) begin
                     we_d    = 1'b1;
                     waddr_d = pend_addr_q;
                     din_d   = pend_byte_q;
                  end
                  pend_valid_d = 1'b1;
                  pend_addr_d  = se_addr;
                  pend_byte_d  = lb_merge_byte(8'h00, se_bitofs, se_width, se_value);
               end
            end
            if (ctu_done) state_d = LB_FLUSH;
         end

         LB_FLUSH: begin
            if (pend_valid_q) begin
               we_d    = 1'b1;
               waddr_d = pend_addr_q;
               din_d   = pend_byte_q;
            end
            pend_valid_d = 1'b0;
            state_d      = LB_SWITCH;
         end

         LB_SWITCH: begin
            switch_d = 1'b1;
            state_d  = LB_IDLE;
         end

         default: state_d = LB_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the pending
   // byte is plain state (not a memory) and is cleared by reset with the rest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= LB_IDLE;
         clr_cnt_q    <= '0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_byte_q  <= 8'h00;
         lb_we        <= 1'b0;
         lb_waddr     <= '0;
         lb_din       <= 8'h00;
         lb_switch    <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_byte_q  <= pend_byte_d;
         lb_we        <= we_d;
         lb_waddr     <= waddr_d;
         lb_din       <= din_d;
         lb_switch    <= switch_d;
         busy         <= (state_q != LB_IDLE);
         err          <= err_d;
      end
   end

endmodule
